ft245_frame_packer: RTL
=======================

Name: ft245_frame_packer

Overview:
- Upstream feeder for the FT245 write-side controller.
- Buffers 16-bit spectrometer samples in an internal FIFO and frames them into a byte stream: sync header, sequence number, big-endian payload, optional checksum.
- Presents bytes on a valid/ready interface that the FT245 writer drains as TXE permits.
- Never emits a partial frame: a frame starts only once a full frame of samples is buffered.

Parameters:
- FRAME_LEN, 128, samples per frame (>=1).
- FIFO_DEPTH, 512, sample FIFO entries; power of two, >= 2*FRAME_LEN.
- SYNC0, 8'h55, first header byte.
- SYNC1, 8'hAA, second header byte.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  16  sample word.
- s_valid  in  1  sample strobe; no backpressure to the source.
- clr_ovf  in  1  clears the overflow flag (one-cycle pulse).
- m_data  out  8  byte to the FT245 writer.
- m_valid  out  1  m_data valid.
- m_ready  in  1  writer accepts the byte.
- overflow  out  1  sticky: a sample was dropped.
- fifo_level  out  log2(FIFO_DEPTH)+1  samples currently buffered.
- frame_active  out  1  high from SYNC0 until the last byte of the frame is accepted.

Behaviour:
- Reset: async, active-high (rst), one clock (clk). While rst is high:
  - m_valid=0, m_data=0, overflow=0, frame_active=0, fifo_level=0.
  - Sequence counter = 0; FSM = IDLE; FIFO flushed.
- FIFO write: on s_valid with fifo_level<FIFO_DEPTH, store s_data; level updates next cycle.
- FIFO full:
  - s_valid with level==FIFO_DEPTH drops the sample and sets overflow the next cycle.
  - A pop in the same cycle does not rescue the write; the sample is still dropped.
- Overflow flag:
  - clr_ovf clears overflow.
  - If a drop and clr_ovf coincide, overflow stays set.
- FIFO read: first-word-fall-through; head sample readable combinationally at the read pointer. Pointers wrap modulo FIFO_DEPTH.
- fifo_level reflects simultaneous push+pop as net zero.
- FSM states: IDLE, HDR0, HDR1, SEQ, DATA_HI, DATA_LO, CSUM.
  - IDLE -> HDR0 when fifo_level>=FRAME_LEN. m_valid=1 and m_data=SYNC0 on the next cycle (1-cycle latency).
  - Each state holds until m_valid&&m_ready, then advances and loads the next byte into the registered m_data in the same edge. Zero bubbles: back-to-back bytes when m_ready stays high.
  - HDR0 (SYNC0) -> HDR1 (SYNC1) -> SEQ (sequence byte) -> DATA_HI (head[15:8]) -> DATA_LO (head[7:0]).
  - Acceptance of DATA_LO pops the FIFO and decrements the internal sample counter.
  - DATA_LO -> DATA_HI while samples remain in the frame; after the last sample -> CSUM if enabled, else IDLE.
  - Leaving the frame: sequence increments (8-bit, 255 wraps to 0). If fifo_level (post-pop) >= FRAME_LEN, go directly to HDR0 with no idle cycle; else IDLE with m_valid=0.
- Output stability: while m_valid=1 and m_ready=0, m_data and state are frozen.
- Frame length: 3 + 2*FRAME_LEN bytes, plus 1 with checksum.
- Stalls on m_ready never lose samples; incoming samples continue to fill the FIFO up to full.
- Reset mid-frame: frame abandoned, no tail emitted; sequence restarts at 0.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- Defined:
  - CSUM state emits an 8-bit modulo-256 sum of SEQ plus all payload bytes; header bytes excluded.
  - Accumulator clears at HDR0.
  - Frame length 4 + 2*FRAME_LEN.
- Undefined:
  - No CSUM state or accumulator.
  - DATA_LO of the last sample returns to IDLE/HDR0.

Test Plan (FRAME_LEN=4, FIFO_DEPTH=8 unless noted):
- Write 4 samples 0x0102,0x0304,0x0506,0x0708, m_ready=1 -> bytes 55 AA 00 01 02 03 04 05 06 07 08; with FRAME_CHECKSUM_EN adds 0x24; m_valid contiguous; fifo_level ends 0.
- Write 3 samples only -> m_valid stays 0; 4th sample -> SYNC0 appears the cycle after fifo_level reaches 4.
- Two full frames buffered, m_ready=1 -> second frame starts immediately after the first with SEQ=01, no idle cycle; 256 frames -> SEQ wraps FF then 00.
- m_ready toggled randomly during a frame -> m_data held while stalled, byte sequence identical to the unstalled run.
- m_ready=0, 10 samples written -> 8 stored, overflow=1, fifo_level=8; clr_ovf pulse -> overflow=0; clr_ovf coincident with a drop -> overflow stays 1.
- rst asserted after 5 bytes of a frame -> m_valid=0 immediately; after release with 4 new samples, frame restarts with SEQ=00.

Source files
------------

// File: rtl/ft245_frame_packer.sv
// Sample FIFO plus byte framer for the FT245 write path: SYNC0 SYNC1 SEQ {hi,lo}*FRAME_LEN [CSUM].
// Optional trailing checksum byte is enabled by defining FRAME_CHECKSUM_EN.
module ft245_frame_packer #(
  parameter int          FRAME_LEN  = 128,
  parameter int          FIFO_DEPTH = 512,
  parameter logic [7:0]  SYNC0      = 8'h55,
  parameter logic [7:0]  SYNC1      = 8'hAA,
  localparam int         AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   s_data,
  input  logic          s_valid,
  input  logic          clr_ovf,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          overflow,
  output logic [AW:0]   fifo_level,
  output logic          frame_active
);

  localparam int         SW      = $clog2(FRAME_LEN + 1);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] FLEN_L  = (AW + 1)'(FRAME_LEN);
  localparam logic [SW-1:0] SLEN_L = SW'(FRAME_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_SEQ,
    ST_DATA_HI,
    ST_DATA_LO
`ifdef FRAME_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_t;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  state_t        state_q;
  logic [7:0]    m_data_q;
  logic          m_valid_q;
  logic          active_q;
  logic [7:0]    seq_q;
  logic [SW-1:0] left_q;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  logic        accept, push, drop, pop, frame_done;
  logic [15:0] head;
  logic [7:0]  nxt_hi;

  assign accept = m_valid_q & m_ready;
  // A full FIFO drops the sample even if a pop happens on the same edge.
  assign push   = s_valid & (count_q != DEPTH_L);
  assign drop   = s_valid & (count_q == DEPTH_L);
  assign pop    = accept & (state_q == ST_DATA_LO);
  assign head   = mem_q[rd_ptr_q];
  assign nxt_hi = mem_q[rd_ptr_q + AW'(1)][15:8];

`ifdef FRAME_CHECKSUM_EN
  assign frame_done = accept & (state_q == ST_CSUM);
`else
  assign frame_done = accept & (state_q == ST_DATA_LO) & (left_q == SW'(1));
`endif

  always_comb begin
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ovf_d   = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      active_q  <= 1'b0;
      seq_q     <= 8'h00;
      left_q    <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else if (frame_done) begin
      // Chain straight into the next frame when enough samples are already waiting.
      seq_q <= seq_q + 8'd1;
      if (count_d >= FLEN_L) begin
        state_q   <= ST_HDR0;
        m_data_q  <= SYNC0;
        m_valid_q <= 1'b1;
        active_q  <= 1'b1;
        left_q    <= SLEN_L;
`ifdef FRAME_CHECKSUM_EN
        csum_q    <= 8'h00;
`endif
      end else begin
        state_q   <= ST_IDLE;
        m_valid_q <= 1'b0;
        active_q  <= 1'b0;
      end
    end else begin
`ifdef FRAME_CHECKSUM_EN
      if (accept && (state_q == ST_SEQ || state_q == ST_DATA_HI || state_q == ST_DATA_LO))
        csum_q <= csum_q + m_data_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (count_q >= FLEN_L) begin
            state_q   <= ST_HDR0;
            m_data_q  <= SYNC0;
            m_valid_q <= 1'b1;
            active_q  <= 1'b1;
            left_q    <= SLEN_L;
`ifdef FRAME_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
          end
        end
        ST_HDR0: if (accept) begin
          state_q  <= ST_HDR1;
          m_data_q <= SYNC1;
        end
        ST_HDR1: if (accept) begin
          state_q  <= ST_SEQ;
          m_data_q <= seq_q;
        end
        ST_SEQ: if (accept) begin
          state_q  <= ST_DATA_HI;
          m_data_q <= head[15:8];
        end
        ST_DATA_HI: if (accept) begin
          state_q  <= ST_DATA_LO;
          m_data_q <= head[7:0];
        end
        ST_DATA_LO: if (accept) begin
          left_q <= left_q - SW'(1);
`ifdef FRAME_CHECKSUM_EN
          if (left_q == SW'(1)) begin
            state_q  <= ST_CSUM;
            m_data_q <= csum_q + m_data_q;
          end else begin
            state_q  <= ST_DATA_HI;
            m_data_q <= nxt_hi;
          end
`else
          state_q  <= ST_DATA_HI;
          m_data_q <= nxt_hi;
`endif
        end
        default: begin
          state_q   <= ST_IDLE;
          m_valid_q <= 1'b0;
          active_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign overflow     = ovf_q;
  assign fifo_level   = count_q;
  assign frame_active = active_q;

endmodule
